// File: rtl/cache_2way_param_if.sv
// rtl/cache_2way_param_if.sv - CPU request port and RAM port bundle for cache_2way_param
interface cache_2way_param_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_ready, cpu_done, cpu_hit, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_ready, cpu_done, cpu_hit, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_2way_param.sv
// rtl/cache_2way_param.sv - two-way set-associative write-back cache with per-set LRU
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module cache_2way_param #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3,
    parameter int IDX_W  = 2
) (
    input  logic               clock,
    input  logic               reset,
    cache_2way_param_if.slave  bus,
    output logic [2:0]         state
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
    output logic [15:0]        wb_cnt
`endif
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    generate
        if (ADDR_W <= IDX_W) begin : g_bad_params
            $error("cache_2way_param: ADDR_W must exceed IDX_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        FILL = 3'd2,
        RESP = 3'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0][SETS-1:0] valid, dirty;
    logic [SETS-1:0]      lru;
    logic [TAG_W-1:0]     tag_mem  [2][SETS];
    logic [DATA_W-1:0]    data_mem [2][SETS];

    logic              req_we, req_hit, vic_way;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata, rdata_q;

    logic [IDX_W-1:0] idx_in, l_idx;
    logic [TAG_W-1:0] tag_in, l_tag;
    logic             hit0, hit1, lk_hit, hit_way, miss_way, miss_dirty;

    assign idx_in = bus.cpu_addr[IDX_W-1:0];
    assign tag_in = bus.cpu_addr[ADDR_W-1:IDX_W];
    assign l_idx  = req_addr[IDX_W-1:0];
    assign l_tag  = req_addr[ADDR_W-1:IDX_W];

    assign hit0    = valid[0][idx_in] && (tag_mem[0][idx_in] == tag_in);
    assign hit1    = valid[1][idx_in] && (tag_mem[1][idx_in] == tag_in);
    assign lk_hit  = hit0 || hit1;
    assign hit_way = hit1;
    // Fill an empty way before evicting anything; way0 wins when both are empty.
    assign miss_way   = !valid[0][idx_in] ? 1'b0 :
                        !valid[1][idx_in] ? 1'b1 : lru[idx_in];
    assign miss_dirty = valid[miss_way][idx_in] && dirty[miss_way][idx_in];

    logic              wr_en, wr_way, wr_dirty;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              ready_c, done_c, hit_c, mreq_c, mwe_c;
    logic [ADDR_W-1:0] maddr_c;
    logic [DATA_W-1:0] mwdata_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        wr_way   = 1'b0;
        wr_dirty = 1'b0;
        wr_idx   = idx_in;
        wr_tag   = tag_in;
        wr_data  = bus.cpu_wdata;
        ready_c  = 1'b0;
        done_c   = 1'b0;
        hit_c    = 1'b0;
        mreq_c   = 1'b0;
        mwe_c    = 1'b0;
        maddr_c  = '0;
        mwdata_c = '0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.cpu_req) begin
                    if (lk_hit) begin
                        state_d = RESP;
                        if (bus.cpu_we) begin
                            wr_en    = 1'b1;
                            wr_way   = hit_way;
                            wr_dirty = 1'b1;
                        end
                    end else if (miss_dirty) begin
                        state_d = WB;
                    end else if (bus.cpu_we) begin
                        // One word is the whole line, so a write miss never fetches.
                        state_d  = RESP;
                        wr_en    = 1'b1;
                        wr_way   = miss_way;
                        wr_dirty = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WB: begin
                mreq_c   = 1'b1;
                mwe_c    = 1'b1;
                maddr_c  = {tag_mem[vic_way][l_idx], l_idx};
                mwdata_c = data_mem[vic_way][l_idx];
                if (bus.mem_ack) begin
                    if (req_we) begin
                        state_d  = RESP;
                        wr_en    = 1'b1;
                        wr_way   = vic_way;
                        wr_idx   = l_idx;
                        wr_tag   = l_tag;
                        wr_data  = req_wdata;
                        wr_dirty = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mreq_c  = 1'b1;
                maddr_c = req_addr;
                if (bus.mem_ack) begin
                    state_d = RESP;
                    wr_en   = 1'b1;
                    wr_way  = vic_way;
                    wr_idx  = l_idx;
                    wr_tag  = l_tag;
                    wr_data = bus.mem_rdata;
                end
            end
            RESP: begin
                done_c  = 1'b1;
                hit_c   = req_hit;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            dirty     <= '0;
            lru       <= '0;
            req_we    <= 1'b0;
            req_hit   <= 1'b0;
            vic_way   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == IDLE && bus.cpu_req) begin
                req_we      <= bus.cpu_we;
                req_addr    <= bus.cpu_addr;
                req_wdata   <= bus.cpu_wdata;
                req_hit     <= lk_hit;
                vic_way     <= lk_hit ? hit_way : miss_way;
                lru[idx_in] <= lk_hit ? ~hit_way : ~miss_way;
                if (lk_hit && !bus.cpu_we)
                    rdata_q <= data_mem[hit_way][idx_in];
            end
            if (state_q == WB && bus.mem_ack && !req_we)
                dirty[vic_way][l_idx] <= 1'b0;
            if (state_q == FILL && bus.mem_ack)
                rdata_q <= bus.mem_rdata;
            if (wr_en) begin
                valid[wr_way][wr_idx] <= 1'b1;
                dirty[wr_way][wr_idx] <= wr_dirty;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_way][wr_idx]  <= wr_tag;
            data_mem[wr_way][wr_idx] <= wr_data;
        end
    end

    assign bus.cpu_ready = ready_c;
    assign bus.cpu_done  = done_c;
    assign bus.cpu_hit   = hit_c;
    assign bus.cpu_rdata = rdata_q;
    assign bus.mem_req   = mreq_c;
    assign bus.mem_we    = mwe_c;
    assign bus.mem_addr  = maddr_c;
    assign bus.mem_wdata = mwdata_c;
    assign state         = state_q;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state_q == RESP && req_hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (state_q == RESP && !req_hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (state_q == WB && bus.mem_ack && wb_cnt != 16'hFFFF)
                wb_cnt <= wb_cnt + 16'd1;
        end
    end
`endif
endmodule
